// File: rtl/tick_sched_pkg.sv
// Shared address map and config-decode types for the tick scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tick_sched_pkg;

    localparam int ADDR_PRESCALE = 0;
    localparam int ADDR_CH_BASE  = 1;

    // Classification of an accepted config write.
    typedef enum logic [1:0] {
        CFG_PRESCALE = 2'd0,
        CFG_CHANNEL  = 2'd1,
        CFG_BAD      = 2'd2
    } cfg_kind_e;

    // Config address of channel k's period register.
    function automatic int ch_addr(input int k);
        return ADDR_CH_BASE + k;
    endfunction

endpackage

// File: rtl/tick_channel.sv
// One scheduled channel: counts base ticks against a written period, emits tick/toggle.
// Latency: o_tick is registered one cycle after the completing base tick is seen.
// Backpressure: none; a write always takes priority over a completing count.
//
// Ports:
//   i_clk, i_rst_n  clock / async active-low reset
//   i_base_tick     shared prescaler pulse (one cycle)
//   i_wr_en         load i_wr_period and restart the count
//   i_wr_period     new period; 0 disables the channel
//   o_tick          one-cycle pulse per completed period
//   o_toggle        flips on every o_tick
module tick_channel #(
    parameter int PERIOD_W = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_base_tick,
    input  logic                i_wr_en,
    input  logic [PERIOD_W-1:0] i_wr_period,
    output logic                o_tick,
    output logic                o_toggle
);

    logic [PERIOD_W-1:0] r_period;
    logic [PERIOD_W-1:0] r_cnt;
    logic                r_tick;
    logic                r_toggle;
    logic                w_enabled;
    logic                w_last;

    assign w_enabled = (r_period != '0);
    // Only meaningful while enabled, so period-1 never underflows in use.
    assign w_last    = (r_cnt == (r_period - PERIOD_W'(1)));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_period <= '0;
            r_cnt    <= '0;
            r_tick   <= 1'b0;
            r_toggle <= 1'b0;
        end else if (i_wr_en) begin
            // A write restarts the phase and suppresses any completion on this edge.
            r_period <= i_wr_period;
            r_cnt    <= '0;
            r_tick   <= 1'b0;
        end else if (i_base_tick && w_enabled) begin
            if (w_last) begin
                r_cnt    <= '0;
                r_tick   <= 1'b1;
                r_toggle <= ~r_toggle;
            end else begin
                r_cnt    <= r_cnt + PERIOD_W'(1);
                r_tick   <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign o_tick   = r_tick;
    assign o_toggle = r_toggle;

endmodule

// File: rtl/tick_scheduler.sv
// Shared prescaler plus N_CH programmable periodic enables, configured over a valid/ready port.
// Latency: all outputs registered; config takes effect from the edge after acceptance.
// Backpressure: o_cfg_ready drops for exactly one cycle after each accepted write.
//
// Ports:
//   i_clk, i_rst_n        clock / async active-low reset
//   i_run                 1 = time base advances, 0 = freeze
//   i_cfg_valid/o_cfg_ready, i_cfg_addr, i_cfg_data   config write port
//                         (addr 0 = prescaler reload, addr k+1 = period of channel k)
//   o_cfg_err             one-cycle pulse after an accepted out-of-range write
//   o_base_tick           one-cycle pulse per prescaler wrap
//   o_ch_tick/o_ch_toggle per-channel enable pulse and square wave
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter int          N_CH           = 4,
    parameter int          PRESCALE_W     = 25,
    parameter int          PERIOD_W       = 8,
    parameter int unsigned PRESCALE_RESET = 24_999_999,
    localparam int         ADDR_W         = $clog2(N_CH + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_run,
    input  logic                  i_cfg_valid,
    output logic                  o_cfg_ready,
    input  logic [ADDR_W-1:0]     i_cfg_addr,
    input  logic [PRESCALE_W-1:0] i_cfg_data,
    output logic                  o_cfg_err,
    output logic                  o_base_tick,
    output logic [N_CH-1:0]       o_ch_tick,
    output logic [N_CH-1:0]       o_ch_toggle
);

    logic [PRESCALE_W-1:0] r_reload;
    logic [PRESCALE_W-1:0] r_pre_cnt;
    logic                  r_base_tick;
    logic                  r_cfg_ready;
    logic                  r_cfg_err;

    logic                  w_accept;
    cfg_kind_e             w_kind;
    logic                  w_wr_pre;
    logic                  w_wr_bad;
    logic [N_CH-1:0]       w_ch_wr;

    assign w_accept = i_cfg_valid && r_cfg_ready;

    always_comb begin
        w_kind = CFG_BAD;
        if (i_cfg_addr == ADDR_W'(ADDR_PRESCALE)) begin
            w_kind = CFG_PRESCALE;
        end else if (i_cfg_addr <= ADDR_W'(N_CH)) begin
            w_kind = CFG_CHANNEL;
        end
    end

    assign w_wr_pre = w_accept && (w_kind == CFG_PRESCALE);
    assign w_wr_bad = w_accept && (w_kind == CFG_BAD);

    // Prescaler. A reload write clears the count and drops any wrap on the same edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_reload    <= PRESCALE_W'(PRESCALE_RESET);
            r_pre_cnt   <= '0;
            r_base_tick <= 1'b0;
        end else if (w_wr_pre) begin
            r_reload    <= i_cfg_data;
            r_pre_cnt   <= '0;
            r_base_tick <= 1'b0;
        end else if (i_run) begin
            if (r_pre_cnt == r_reload) begin
                r_pre_cnt   <= '0;
                r_base_tick <= 1'b1;
            end else begin
                r_pre_cnt   <= r_pre_cnt + PRESCALE_W'(1);
                r_base_tick <= 1'b0;
            end
        end else begin
            r_base_tick <= 1'b0;
        end
    end

    // One accept every other cycle: ready is simply the inverse of last cycle's accept.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cfg_ready <= 1'b1;
            r_cfg_err   <= 1'b0;
        end else begin
            r_cfg_ready <= !w_accept;
            r_cfg_err   <= w_wr_bad;
        end
    end

    // Channels consume the registered base tick directly. With i_run low the
    // prescaler emits no new pulse, so channel counts hold; a pulse registered
    // just before the freeze is still honoured, as it was earned while running.
    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        assign w_ch_wr[k] = w_accept && (w_kind == CFG_CHANNEL) &&
                            (i_cfg_addr == ADDR_W'(ch_addr(k)));

        tick_channel #(
            .PERIOD_W (PERIOD_W)
        ) u_channel (
            .i_clk       (i_clk),
            .i_rst_n     (i_rst_n),
            .i_base_tick (r_base_tick),
            .i_wr_en     (w_ch_wr[k]),
            .i_wr_period (i_cfg_data[PERIOD_W-1:0]),
            .o_tick      (o_ch_tick[k]),
            .o_toggle    (o_ch_toggle[k])
        );
    end

    assign o_cfg_ready = r_cfg_ready;
    assign o_cfg_err   = r_cfg_err;
    assign o_base_tick = r_base_tick;

endmodule
